// File: rtl/mandelbrot_example_pkg.sv
// Shared types and width helpers for the mandelbrot example read-stream FIFO.
package mandelbrot_example_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2
    } rd_fifo_state_t;

    localparam int RD_FIFO_MIN_IDX_W = 1;

    // Number of narrow output words carried by one wide input beat.
    function automatic int rd_fifo_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // Index width for n items; never narrower than one bit so RATIO==1 still has a counter.
    function automatic int rd_fifo_idx_w(input int n);
        return (n > 1) ? $clog2(n) : RD_FIFO_MIN_IDX_W;
    endfunction

endpackage

// File: rtl/mandelbrot_example_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output, no array reset.
module mandelbrot_example_sdp_ram #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 6
) (
    input  logic              aclk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/mandelbrot_example_rd_stream_fifo.sv
// Landing buffer for one read channel: stores wide beats, serializes them LSB-first into narrow words.
// Optional statistics ports (max_count, drop_cnt) are built when MANDELBROT_RD_FIFO_STATS_EN is defined.
module mandelbrot_example_rd_stream_fifo
    import mandelbrot_example_pkg::*;
#(
    parameter int C_IN_WIDTH         = 512,
    parameter int C_OUT_WIDTH        = 32,
    parameter int C_DEPTH            = 64,
    parameter int C_PROG_FULL_THRESH = 48
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [C_IN_WIDTH-1:0]  s_tdata,
    output logic                   prog_full,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [C_OUT_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    output logic                   overflow
`ifdef MANDELBROT_RD_FIFO_STATS_EN
    ,
    output logic [$clog2(C_DEPTH):0] max_count,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int RATIO  = rd_fifo_ratio(C_IN_WIDTH, C_OUT_WIDTH);
    localparam int SUB_W  = rd_fifo_idx_w(RATIO);
    localparam int ADDR_W = $clog2(C_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0]     wr_ptr_reg;
    logic [ADDR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;
    rd_fifo_state_t        state_reg;
    logic [SUB_W-1:0]      sub_idx_reg;
    logic [C_IN_WIDTH-1:0] hold_reg;
    logic                  m_tvalid_reg;
    logic                  prog_full_reg;
    logic                  overflow_reg;
    logic [C_IN_WIDTH-1:0] rd_data;
    logic [C_OUT_WIDTH-1:0] words [RATIO];

    logic full;
    logic wr_en;
    logic rd_en;
    logic handshake;
    logic last_word;

    assign full      = (count_reg == CNT_W'(C_DEPTH));
    assign wr_en     = s_tvalid && !full;
    assign handshake = m_tvalid_reg && m_tready;
    assign last_word = (sub_idx_reg == SUB_W'(RATIO - 1));
    // A fetch is issued from IDLE, or back-to-back as the last word of the held beat leaves.
    assign rd_en     = (count_reg != '0) &&
                       ((state_reg == IDLE) || ((state_reg == SHIFT) && handshake && last_word));

    always_comb begin
        count_next = count_reg;
        if (wr_en && !rd_en) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!wr_en && rd_en) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    mandelbrot_example_sdp_ram #(
        .DATA_W (C_IN_WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .aclk    (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg),
        .wr_data (s_tdata),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            prog_full_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            end
            count_reg     <= count_next;
            prog_full_reg <= (count_next >= CNT_W'(C_PROG_FULL_THRESH));
            if (s_tvalid && full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg    <= IDLE;
            sub_idx_reg  <= '0;
            m_tvalid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rd_en) begin
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    sub_idx_reg  <= '0;
                    m_tvalid_reg <= 1'b1;
                    state_reg    <= SHIFT;
                end
                SHIFT: begin
                    if (handshake) begin
                        if (last_word) begin
                            m_tvalid_reg <= 1'b0;
                            state_reg    <= rd_en ? FETCH : IDLE;
                        end else begin
                            sub_idx_reg <= sub_idx_reg + SUB_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    m_tvalid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Hold register needs no reset: it is only observed while m_tvalid is high.
    always_ff @(posedge aclk) begin
        if (state_reg == FETCH) begin
            hold_reg <= rd_data;
        end
    end

    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_words
            assign words[gi] = hold_reg[gi*C_OUT_WIDTH +: C_OUT_WIDTH];
        end
    endgenerate

    assign s_tready  = !full;
    assign prog_full = prog_full_reg;
    assign overflow  = overflow_reg;
    assign m_tvalid  = m_tvalid_reg;
    assign m_tdata   = words[sub_idx_reg];
    assign m_tlast   = m_tvalid_reg && last_word;

`ifdef MANDELBROT_RD_FIFO_STATS_EN
    logic [CNT_W-1:0] max_count_reg;
    logic [15:0]      drop_cnt_reg;

    always_ff @(posedge aclk) begin
        if (areset) begin
            max_count_reg <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            if (count_next > max_count_reg) begin
                max_count_reg <= count_next;
            end
            if (s_tvalid && full && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign max_count = max_count_reg;
    assign drop_cnt  = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_mandelbrot_example_rd_stream_fifo.sv
// Bench for the read-stream FIFO: queue-based reference model plus per-scenario tasks.
module tb_mandelbrot_example_rd_stream_fifo;

    localparam int C_IN_WIDTH         = 64;
    localparam int C_OUT_WIDTH        = 16;
    localparam int C_DEPTH            = 8;
    localparam int C_PROG_FULL_THRESH = 6;
    localparam int RATIO              = C_IN_WIDTH / C_OUT_WIDTH;

    logic                   aclk = 1'b0;
    logic                   areset = 1'b1;
    logic                   s_tvalid = 1'b0;
    logic                   s_tready;
    logic [C_IN_WIDTH-1:0]  s_tdata = '0;
    logic                   prog_full;
    logic                   m_tvalid;
    logic                   m_tready = 1'b0;
    logic [C_OUT_WIDTH-1:0] m_tdata;
    logic                   m_tlast;
    logic                   overflow;
`ifdef MANDELBROT_RD_FIFO_STATS_EN
    logic [$clog2(C_DEPTH):0] max_count;
    logic [15:0]              drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: beats waiting in RAM, words left in the current beat, one fetch in flight.
    logic [C_IN_WIDTH-1:0]  mq[$];
    logic [C_OUT_WIDTH-1:0] mw[$];
    logic [C_OUT_WIDTH-1:0] sb[$];
    bit                     mfetch = 0;
    logic [C_IN_WIDTH-1:0]  mfetched;
    bit                     movf = 0;

    mandelbrot_example_rd_stream_fifo #(
        .C_IN_WIDTH         (C_IN_WIDTH),
        .C_OUT_WIDTH        (C_OUT_WIDTH),
        .C_DEPTH            (C_DEPTH),
        .C_PROG_FULL_THRESH (C_PROG_FULL_THRESH)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .prog_full (prog_full),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .overflow  (overflow)
`ifdef MANDELBROT_RD_FIFO_STATS_EN
        ,
        .max_count (max_count),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    function automatic bit model_busy();
        return (mq.size() > 0) || (mw.size() > 0) || mfetch;
    endfunction

    // Advance DUT and model by one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        bit hs;
        bit take;
        bit wr_ok;
        if (areset) begin
            @(posedge aclk);
            mq.delete(); mw.delete(); sb.delete();
            mfetch = 0; movf = 0;
            #1;
            return;
        end
        hs    = (mw.size() > 0) && m_tready;
        take  = (mq.size() > 0) && (((mw.size() == 0) && !mfetch) || (hs && (mw.size() == 1)));
        wr_ok = s_tvalid && (mq.size() < C_DEPTH);
        @(posedge aclk);
        if (hs) void'(mw.pop_front());
        if (mfetch) begin
            for (int k = 0; k < RATIO; k++) mw.push_back(mfetched[k*C_OUT_WIDTH +: C_OUT_WIDTH]);
            mfetch = 0;
        end
        if (take) begin
            mfetched = mq.pop_front();
            mfetch = 1;
        end
        if (wr_ok) begin
            mq.push_back(s_tdata);
            for (int k = 0; k < RATIO; k++) sb.push_back(s_tdata[k*C_OUT_WIDTH +: C_OUT_WIDTH]);
        end else if (s_tvalid) begin
            movf = 1;
        end
        #1;
    endtask

    task automatic apply_reset();
        areset = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0;
        step();
        step();
        areset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got=%b want=0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_m_tlast got=%b want=0", m_tlast); end
        checks++; if (prog_full !== 1'b0) begin errors++; $display("FAIL reset_prog_full got=%b want=0", prog_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready got=%b want=1", s_tready); end
        $display("reset: m_tvalid=%b prog_full=%b overflow=%b s_tready=%b", m_tvalid, prog_full, overflow, s_tready);
    endtask

    task automatic test_single_beat();
        logic [15:0] exp_w [4];
        exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        apply_reset();
        m_tready = 1'b1;
        s_tvalid = 1'b1; s_tdata = 64'h4444_3333_2222_1111;
        step();
        s_tvalid = 1'b0;
        step();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b want=0", m_tvalid); end
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== exp_w[i] || m_tlast !== (i == 3)) begin
                errors++;
                $display("FAIL single_word%0d got valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                         i, m_tvalid, m_tdata, m_tlast, exp_w[i], (i == 3));
            end
            $display("single: word %0d data=%h last=%b", i, m_tdata, m_tlast);
            step();
        end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_after_valid got=%b want=0", m_tvalid); end
    endtask

    task automatic test_backpressure();
        int nhs = 0;
        int hold_left = 0;
        bit hold_done = 0;
        logic [15:0] held = '0;
        logic [15:0] exp_d;
        apply_reset();
        for (int cyc = 0; cyc < 80 && nhs < 2*RATIO; cyc++) begin
            s_tvalid = (cyc < 2);
            s_tdata  = {$urandom, $urandom};
            m_tready = (hold_left == 0);
            if (hold_left > 0) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== held) begin
                    errors++;
                    $display("FAIL bp_hold got valid=%b data=%h want valid=1 data=%h", m_tvalid, m_tdata, held);
                end
                hold_left--;
            end
            if (m_tvalid && m_tready) begin
                exp_d = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
                checks++;
                if (m_tdata !== exp_d) begin
                    errors++;
                    $display("FAIL bp_word%0d got=%h want=%h", nhs, m_tdata, exp_d);
                end
                $display("backpressure: word %0d data=%h", nhs, m_tdata);
                nhs++;
            end
            step();
            if (nhs == 2 && !hold_done && mw.size() > 0) begin
                hold_done = 1; hold_left = 5; held = mw[0];
            end
        end
        s_tvalid = 1'b0;
        checks++; if (nhs != 2*RATIO || sb.size() != 0) begin errors++; $display("FAIL bp_count got=%0d want=%0d", nhs, 2*RATIO); end
    endtask

    task automatic test_fill();
        apply_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_tvalid = 1'b1; s_tdata = {$urandom, $urandom};
            step();
            checks++;
            if (prog_full !== 1'((mq.size() >= C_PROG_FULL_THRESH))) begin
                errors++;
                $display("FAIL fill_pf_w%0d got=%b want=%b", i, prog_full, (mq.size() >= C_PROG_FULL_THRESH));
            end
            $display("fill: write %0d prog_full=%b", i, prog_full);
        end
        s_tvalid = 1'b0;
        checks++; if (prog_full !== 1'b1) begin errors++; $display("FAIL fill_pf_high got=%b want=1", prog_full); end
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 80 && model_busy(); cyc++) begin
            step();
            checks++;
            if (prog_full !== 1'((mq.size() >= C_PROG_FULL_THRESH)) || m_tvalid !== 1'((mw.size() > 0))) begin
                errors++;
                $display("FAIL fill_drain got pf=%b valid=%b want pf=%b valid=%b", prog_full, m_tvalid,
                         (mq.size() >= C_PROG_FULL_THRESH), (mw.size() > 0));
            end
        end
        checks++; if (model_busy() || m_tvalid !== 1'b0) begin errors++; $display("FAIL fill_drain_timeout got valid=%b want=0", m_tvalid); end
    endtask

    task automatic test_overflow();
        int nout = 0;
        logic [15:0] exp_d;
        apply_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_tvalid = 1'b1; s_tdata = {$urandom, $urandom};
            checks++;
            if (s_tready !== 1'((mq.size() < C_DEPTH))) begin
                errors++; $display("FAIL ovf_s_tready%0d got=%b want=%b", i, s_tready, (mq.size() < C_DEPTH));
            end
            step();
            checks++;
            if (overflow !== 1'(movf)) begin
                errors++; $display("FAIL ovf_flag%0d got=%b want=%b", i, overflow, movf);
            end
            $display("overflow: write %0d overflow=%b s_tready=%b", i, overflow, s_tready);
        end
        s_tvalid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", overflow); end
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 150 && model_busy(); cyc++) begin
            if (m_tvalid) begin
                exp_d = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
                checks++;
                if (m_tdata !== exp_d) begin errors++; $display("FAIL ovf_drain%0d got=%h want=%h", nout, m_tdata, exp_d); end
                nout++;
            end
            step();
        end
        checks++; if (sb.size() != 0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL ovf_drain_left got=%0d want=0", sb.size()); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
        $display("overflow: drained %0d words", nout);
    endtask

    task automatic test_reset_mid();
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1; s_tdata = {$urandom, $urandom};
            step();
        end
        s_tvalid = 1'b0;
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got=%b want=1", m_tvalid); end
        areset = 1'b1;
        step();
        areset = 1'b0;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_m_tvalid got=%b want=0", m_tvalid); end
        checks++; if (prog_full !== 1'b0) begin errors++; $display("FAIL rmid_prog_full got=%b want=0", prog_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow got=%b want=0", overflow); end
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_idle%0d got=%b want=0", i, m_tvalid); end
        end
        s_tvalid = 1'b1; s_tdata = 64'hDDDD_CCCC_BBBB_AAAA;
        step();
        s_tvalid = 1'b0;
        step();
        step();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 16'hAAAA) begin
            errors++; $display("FAIL rmid_new_beat got valid=%b data=%h want valid=1 data=aaaa", m_tvalid, m_tdata);
        end
        $display("reset_mid: new beat first word=%h", m_tdata);
        for (int cyc = 0; cyc < 20 && model_busy(); cyc++) step();
    endtask

    task automatic test_wrap();
        int next_beat = 0;
        int nw = 0;
        apply_reset();
        for (int cyc = 0; cyc < 3000 && nw < 40*RATIO; cyc++) begin
            s_tvalid = (next_beat < 40) && (mq.size() < C_DEPTH) && ($urandom_range(0, 2) != 0);
            s_tdata  = {16'(4*next_beat+3), 16'(4*next_beat+2), 16'(4*next_beat+1), 16'(4*next_beat)};
            m_tready = ($urandom_range(0, 3) != 0);
            if (m_tvalid && m_tready) begin
                checks++;
                if (m_tdata !== 16'(nw) || m_tlast !== ((nw % RATIO) == RATIO-1)) begin
                    errors++;
                    $display("FAIL wrap_word%0d got data=%h last=%b want data=%h last=%b", nw, m_tdata, m_tlast,
                             16'(nw), ((nw % RATIO) == RATIO-1));
                end
                if ((nw % RATIO) == RATIO-1) $display("wrap: beat %0d done", nw / RATIO);
                nw++;
            end
            step();
            if (s_tvalid) next_beat++;
        end
        s_tvalid = 1'b0;
        checks++; if (nw != 40*RATIO) begin errors++; $display("FAIL wrap_count got=%0d want=%0d", nw, 40*RATIO); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow got=%b want=0", overflow); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_backpressure();
        test_fill();
        test_overflow();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
